uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, frame width,
// and the oversampling divider calculation.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rxState_t;

    // Rounded clocks per 16x-baud tick, never below one cycle.
    function automatic int calcDiv(input int clkHz, input int baud);
        int d;
        d = (clkHz + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word fall-through byte FIFO; the head entry is always visible on o_headData.
// A push is accepted while full only when a pop frees a slot in the same cycle.
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_headData,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_headData = r_mem[r_rdPtr];
    assign w_doPop    = i_pop && !o_empty;
    assign w_doPush   = i_push && (!o_full || w_doPop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= i_pushData;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, sticky frame/overrun flags,
// feeding a first-word fall-through receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic                       UART_RX,
    input  logic                       RX_RD,
    input  logic                       ERR_CLR,
    output logic [7:0]                 RX_DATA,
    output logic                       RX_VALID,
    output logic [$clog2(DEPTH):0]     RX_COUNT,
    output logic                       RX_FRAME_ERR,
    output logic                       RX_OVERRUN
);
    localparam int DIV    = calcDiv(CLK_HZ, BAUD);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    logic                 r_sync1;
    logic                 r_sync2;
    rxState_t             r_state;
    rxState_t             w_nextState;
    logic [TICK_W-1:0]    r_tickCnt;
    logic [3:0]           r_sampleCnt;
    logic [BIT_W-1:0]     r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frameErr;
    logic                 r_overrun;
    logic                 w_line;
    logic                 w_tick;
    logic                 w_midStart;
    logic                 w_bitEnd;
    logic                 w_lastBit;
    logic                 w_clrSample;
    logic                 w_shiftEn;
    logic                 w_push;
    logic                 w_frameErrSet;
    logic                 w_overrunSet;
    logic                 w_full;
    logic                 w_empty;

    assign w_line     = r_sync2;
    assign w_tick     = (r_state != S_IDLE) && (r_tickCnt == TICK_W'(DIV - 1));
    assign w_midStart = w_tick && (r_sampleCnt == 4'd7);
    assign w_bitEnd   = w_tick && (r_sampleCnt == 4'd15);
    assign w_lastBit  = (r_bitCnt == BIT_W'(DATA_BITS - 1));

    // Flops reset high so a reset never looks like a start bit.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= UART_RX;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (!w_line)    w_nextState = S_START;
            S_START: if (w_midStart) w_nextState = w_line ? S_IDLE : S_DATA;
            S_DATA:  if (w_bitEnd && w_lastBit) w_nextState = S_STOP;
            S_STOP:  if (w_bitEnd)   w_nextState = w_line ? S_IDLE : S_BREAK;
            S_BREAK: if (w_line)     w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_clrSample   = 1'b0;
        w_shiftEn     = 1'b0;
        w_push        = 1'b0;
        w_frameErrSet = 1'b0;
        case (r_state)
            S_IDLE:  w_clrSample = 1'b1;
            S_START: w_clrSample = w_midStart;
            S_DATA:  w_shiftEn   = w_bitEnd;
            S_STOP: begin
                w_push        = w_bitEnd && w_line;
                w_frameErrSet = w_bitEnd && !w_line;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset || r_state == S_IDLE) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == TICK_W'(DIV - 1)) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
        end
    end

    // Sample counter wraps every 16 ticks; bit counter wraps after the last data bit.
    always_ff @(posedge sysclk) begin
        if (reset || w_clrSample) begin
            r_sampleCnt <= '0;
            r_bitCnt    <= '0;
        end else begin
            if (w_tick) begin
                r_sampleCnt <= r_sampleCnt + 1'b1;
            end
            if (w_shiftEn) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_shiftEn) begin
            r_shift <= {w_line, r_shift[DATA_BITS-1:1]};
        end
    end

    // A full FIFO with a simultaneous read makes room, so that case is no overrun.
    assign w_overrunSet = w_push && w_full && !RX_RD;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_frameErr <= w_frameErrSet || (r_frameErr && !ERR_CLR);
            r_overrun  <= w_overrunSet  || (r_overrun  && !ERR_CLR);
        end
    end

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_clk      (sysclk),
        .i_reset    (reset),
        .i_push     (w_push),
        .i_pushData (r_shift),
        .i_pop      (RX_RD),
        .o_headData (RX_DATA),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (RX_COUNT)
    );

    assign RX_VALID     = !w_empty;
    assign RX_FRAME_ERR = r_frameErr;
    assign RX_OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based model of received bytes and
// sticky flags, compared every cycle, plus hand-computed checkpoints per scenario.
module tb_uart_rx_fifo;
    localparam int CLK_HZ   = 1600;
    localparam int BAUD     = 25;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int IDLE_CYC = 16;
    // Line falls before edge c+1: 2 sync edges, 1 to leave IDLE, 8 ticks of 4 cycles
    // to mid-start, then 8 data bits and the stop bit at 64 cycles each.
    localparam int PUSH_LAT = 2 + 1 + 8 * 4 + 8 * BIT_CYC + BIT_CYC;

    logic             sysclk  = 1'b0;
    logic             reset   = 1'b1;
    logic             UART_RX = 1'b1;
    logic             RX_RD   = 1'b0;
    logic             ERR_CLR = 1'b0;
    logic [7:0]       RX_DATA;
    logic             RX_VALID;
    logic [CNT_W-1:0] RX_COUNT;
    logic             RX_FRAME_ERR;
    logic             RX_OVERRUN;

    int         nVectors     = 0;
    int         nMiscompares = 0;
    int         cyc          = 0;
    logic [7:0] mq[$];
    bit         mFrameErr    = 1'b0;
    bit         mOverrun     = 1'b0;
    int         evCycle      = -1;
    logic [7:0] evByte       = 8'h00;
    bit         evStopOk     = 1'b1;
    bit         rndDone      = 1'b0;
    int         pushAt;

    uart_rx_fifo #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .RX_RD        (RX_RD),
        .ERR_CLR      (ERR_CLR),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_COUNT     (RX_COUNT),
        .RX_FRAME_ERR (RX_FRAME_ERR),
        .RX_OVERRUN   (RX_OVERRUN)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Sends one 8N1 frame starting at a falling clock edge and registers when its
    // stop bit will be judged.
    task automatic applyStimulus(input logic [7:0] b, input bit stopOk);
        evByte   = b;
        evStopOk = stopOk;
        evCycle  = cyc + PUSH_LAT;
        UART_RX  = 1'b0;
        repeat (BIT_CYC) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (BIT_CYC) @(negedge sysclk);
        end
        UART_RX = stopOk;
        repeat (BIT_CYC) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (IDLE_CYC) @(negedge sysclk);
    endtask

    task automatic popOne();
        RX_RD = 1'b1;
        @(negedge sysclk);
        RX_RD = 1'b0;
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge sysclk);
    endtask

    // Reference model: updated on every rising edge from the inputs and the frame schedule.
    initial begin
        forever begin
            @(posedge sysclk);
            cyc = cyc + 1;
            if (reset) begin
                mq.delete();
                mFrameErr = 1'b0;
                mOverrun  = 1'b0;
            end else begin
                bit stopHere;
                bit pushReq;
                bit frameSet;
                bit ovSet;
                bit doPop;
                stopHere = (cyc == evCycle);
                pushReq  = stopHere && evStopOk;
                frameSet = stopHere && !evStopOk;
                doPop    = RX_RD && (mq.size() > 0);
                ovSet    = pushReq && (mq.size() == DEPTH) && !RX_RD;
                if (doPop) void'(mq.pop_front());
                if (pushReq && !ovSet) mq.push_back(evByte);
                mFrameErr = frameSet || (mFrameErr && !ERR_CLR);
                mOverrun  = ovSet || (mOverrun && !ERR_CLR);
            end
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (cyc > 0) begin
                checkOutput("valid", 32'(RX_VALID), 32'(mq.size() > 0));
                checkOutput("count", 32'(RX_COUNT), 32'(mq.size()));
                if (mq.size() > 0) checkOutput("data", 32'(RX_DATA), 32'(mq[0]));
                checkOutput("frame_err", 32'(RX_FRAME_ERR), 32'(mFrameErr));
                checkOutput("overrun", 32'(RX_OVERRUN), 32'(mOverrun));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge sysclk);
        checkOutput("reset_valid", 32'(RX_VALID), 32'd0);
        checkOutput("reset_count", 32'(RX_COUNT), 32'd0);
        checkOutput("reset_data", 32'(RX_DATA), 32'd0);
        checkOutput("reset_flags", 32'({RX_FRAME_ERR, RX_OVERRUN}), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge sysclk);

        // Single byte with exact arrival timing.
        pushAt = cyc + PUSH_LAT;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                waitUntil(pushAt - 1);
                checkOutput("a5_valid_before", 32'(RX_VALID), 32'd0);
                @(negedge sysclk);
                checkOutput("a5_valid_after", 32'(RX_VALID), 32'd1);
                checkOutput("a5_data", 32'(RX_DATA), 32'hA5);
                checkOutput("a5_count", 32'(RX_COUNT), 32'd1);
            end
        join
        checkOutput("a5_flags", 32'({RX_FRAME_ERR, RX_OVERRUN}), 32'd0);
        popOne();
        checkOutput("a5_popped", 32'(RX_COUNT), 32'd0);

        // Short low glitch must be rejected.
        UART_RX = 1'b0;
        repeat (20) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (100) @(negedge sysclk);
        checkOutput("glitch_count", 32'(RX_COUNT), 32'd0);
        checkOutput("glitch_flags", 32'({RX_FRAME_ERR, RX_OVERRUN}), 32'd0);

        // Framing error, recovery, flag clear.
        applyStimulus(8'h3C, 1'b0);
        checkOutput("ferr_flag", 32'(RX_FRAME_ERR), 32'd1);
        checkOutput("ferr_count", 32'(RX_COUNT), 32'd0);
        applyStimulus(8'h55, 1'b1);
        checkOutput("ferr_next_data", 32'(RX_DATA), 32'h55);
        checkOutput("ferr_next_count", 32'(RX_COUNT), 32'd1);
        ERR_CLR = 1'b1;
        @(negedge sysclk);
        ERR_CLR = 1'b0;
        checkOutput("ferr_cleared", 32'(RX_FRAME_ERR), 32'd0);
        popOne();

        // Overrun: fifth byte dropped.
        for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 1'b1);
        checkOutput("ovr_count", 32'(RX_COUNT), 32'd4);
        checkOutput("ovr_flag", 32'(RX_OVERRUN), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("ovr_order", 32'(RX_DATA), 32'(k));
            popOne();
        end
        checkOutput("ovr_drained", 32'(RX_VALID), 32'd0);
        ERR_CLR = 1'b1;
        @(negedge sysclk);
        ERR_CLR = 1'b0;

        // Full FIFO with a read on the push cycle: both happen, no overrun.
        for (int k = 0; k < 4; k++) applyStimulus(8'h10 + 8'(k), 1'b1);
        pushAt = cyc + PUSH_LAT;
        fork
            applyStimulus(8'h14, 1'b1);
            begin
                waitUntil(pushAt - 1);
                RX_RD = 1'b1;
                @(negedge sysclk);
                RX_RD = 1'b0;
            end
        join
        checkOutput("full_rd_overrun", 32'(RX_OVERRUN), 32'd0);
        checkOutput("full_rd_count", 32'(RX_COUNT), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            checkOutput("full_rd_order", 32'(RX_DATA), 32'h10 + 32'(k));
            popOne();
        end
        RX_RD = 1'b1;
        repeat (3) @(negedge sysclk);
        RX_RD = 1'b0;
        checkOutput("empty_rd_count", 32'(RX_COUNT), 32'd0);

        // Reset in the middle of bit 4 abandons the frame and clears everything.
        applyStimulus(8'h77, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("pre_reset_count", 32'(RX_COUNT), 32'd1);
        checkOutput("pre_reset_ferr", 32'(RX_FRAME_ERR), 32'd1);
        UART_RX = 1'b0;
        repeat (BIT_CYC) @(negedge sysclk);
        for (int i = 0; i < 4; i++) begin
            UART_RX = i[0];
            repeat (BIT_CYC) @(negedge sysclk);
        end
        UART_RX = 1'b1;
        repeat (BIT_CYC / 2) @(negedge sysclk);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        checkOutput("midreset_count", 32'(RX_COUNT), 32'd0);
        checkOutput("midreset_data", 32'(RX_DATA), 32'd0);
        checkOutput("midreset_flags", 32'({RX_VALID, RX_FRAME_ERR, RX_OVERRUN}), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        applyStimulus(8'hC3, 1'b1);
        checkOutput("after_reset_data", 32'(RX_DATA), 32'hC3);
        checkOutput("after_reset_count", 32'(RX_COUNT), 32'd1);
        popOne();

        // Random bytes, random stop bits, random reads and clears against the model.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
                end
                rndDone = 1'b1;
            end
            begin
                while (!rndDone) begin
                    @(negedge sysclk);
                    RX_RD   = ($urandom_range(0, 39) == 0);
                    ERR_CLR = ($urandom_range(0, 149) == 0);
                end
                RX_RD   = 1'b0;
                ERR_CLR = 1'b0;
            end
        join
        for (int k = 0; k < DEPTH + 1; k++) popOne();
        checkOutput("final_empty", 32'(RX_VALID), 32'd0);

        repeat (5) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
